// File: rtl/meas_uart_scheduler.sv
// Shares one uart_send between the CC and DC measurement channels: latches each result and
// sends {SYNC, ID, VALUE} frames with round-robin arbitration and a tx_ready handshake.
module meas_uart_scheduler #(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter logic [7:0] CC_ID       = 8'h01,
   parameter logic [7:0] DC_ID       = 8'h02,
   parameter int         ACC_TIMEOUT = 16
) (
   input  logic        fpga_clk1,
   input  logic        rst_n,
   input  logic [7:0]  cc_value,
   input  logic        cc_valid,
   input  logic [7:0]  dc_value,
   input  logic        dc_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_start,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [7:0]  drop_cnt
);
   localparam int TW = $clog2(ACC_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ARB, LOAD, WAIT_ACC, WAIT_DONE} state_t;

   // channel 0 = CC, channel 1 = DC
   state_t          state_q, state_d;
   logic [1:0][7:0] hold_q, hold_d, shad_q, shad_d;
   logic [1:0]      pend_q, pend_d, shv_q, shv_d;
   logic            last_q, last_d, gnt_q, gnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      tx_byte_q, tx_byte_d;
   logic            tx_start_q, tx_start_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic [7:0]      drop_cnt_q, drop_cnt_d;

   logic [1:0]      vld, active, drops;
   logic [1:0][7:0] val;
   logic            arb_gnt, frame_end;
   logic [8:0]      drop_sum;
   logic [7:0]      load_byte;

   assign vld = {dc_valid, cc_valid};
   assign val = {dc_value, cc_value};

   always_comb begin
      case (pend_q)
         2'b01:   arb_gnt = 1'b0;
         2'b10:   arb_gnt = 1'b1;
         default: arb_gnt = ~last_q;
      endcase
      // a channel owns its frame from the ARB cycle that grants it until the frame ends
      for (int c = 0; c < 2; c++)
         active[c] = ((state_q == ARB) && (arb_gnt == 1'(c))) ||
                     ((state_q inside {LOAD, WAIT_ACC, WAIT_DONE}) && (gnt_q == 1'(c)));
      frame_end = (state_q == WAIT_DONE) && tx_ready && (idx_q == 2'd2);
      case (idx_q)
         2'd0:    load_byte = SYNC_BYTE;
         2'd1:    load_byte = gnt_q ? DC_ID : CC_ID;
         default: load_byte = hold_q[gnt_q];
      endcase
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      shad_d      = shad_q;
      pend_d      = pend_q;
      shv_d       = shv_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      tx_byte_d   = tx_byte_q;
      tx_start_d  = 1'b0;
      frame_cnt_d = frame_cnt_q;
      drops       = 2'b00;

      if (state_q == ARB) begin
         pend_d[arb_gnt] = 1'b0;
         gnt_d           = arb_gnt;
         last_d          = arb_gnt;
         idx_d           = 2'd0;
      end

      // granted hold stays frozen; new samples park in the shadow until frame end
      for (int c = 0; c < 2; c++) begin
         if (vld[c]) begin
            pend_d[c] = 1'b1;
            if (active[c]) begin
               shad_d[c] = val[c];
               shv_d[c]  = 1'b1;
               drops[c]  = shv_q[c];
            end else begin
               hold_d[c] = val[c];
               drops[c]  = pend_q[c];
            end
         end
         if (frame_end && (gnt_q == 1'(c)) && shv_d[c]) begin
            hold_d[c] = shad_d[c];
            shv_d[c]  = 1'b0;
         end
      end

      drop_sum   = {1'b0, drop_cnt_q} + 9'(drops[0]) + 9'(drops[1]);
      drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

      case (state_q)
         IDLE: if (|pend_q) state_d = ARB;
         // SYNC does not depend on the grant, so it can go out straight from ARB
         ARB: begin
            if (tx_ready) begin
               tx_byte_d  = SYNC_BYTE;
               tx_start_d = 1'b1;
               tmo_d      = '0;
               state_d    = WAIT_ACC;
            end else begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (tx_ready) begin
               tx_byte_d  = load_byte;
               tx_start_d = 1'b1;
               tmo_d      = '0;
               state_d    = WAIT_ACC;
            end
         end
         WAIT_ACC: begin
            if (!tx_ready)                            state_d = WAIT_DONE;
            else if (tmo_q == TW'(ACC_TIMEOUT - 1))   state_d = LOAD;
            else                                      tmo_d   = tmo_q + 1'b1;
         end
         WAIT_DONE: begin
            if (tx_ready) begin
               if (idx_q != 2'd2) begin
                  idx_d   = idx_q + 2'd1;
                  state_d = LOAD;
               end else begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge fpga_clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         shad_q      <= '0;
         pend_q      <= '0;
         shv_q       <= '0;
         last_q      <= 1'b1;
         gnt_q       <= 1'b0;
         idx_q       <= '0;
         tmo_q       <= '0;
         tx_byte_q   <= '0;
         tx_start_q  <= 1'b0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         shad_q      <= shad_d;
         pend_q      <= pend_d;
         shv_q       <= shv_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         tx_byte_q   <= tx_byte_d;
         tx_start_q  <= tx_start_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign tx_byte   = tx_byte_q;
   assign tx_start  = tx_start_q;
   assign busy      = (state_q != IDLE);
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_meas_uart_scheduler.sv
// Directed bench for meas_uart_scheduler: UART model records each tx_start byte, a queue of
// expected bytes is filled as stimulus is driven and compared as bytes come out.
module tb_meas_uart_scheduler;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [7:0]  cc_value = '0, dc_value = '0;
   logic        cc_valid = 1'b0, dc_valid = 1'b0, tx_ready = 1'b1;
   logic [7:0]  tx_byte, drop_cnt;
   logic        tx_start, busy;
   logic [15:0] frame_cnt;

   meas_uart_scheduler dut (
      .fpga_clk1(clk), .rst_n(rst_n),
      .cc_value(cc_value), .cc_valid(cc_valid),
      .dc_value(dc_value), .dc_valid(dc_valid),
      .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_start(tx_start),
      .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int         pcyc = 0;
   logic [7:0] exp_q[$], obs_b[$];
   int         obs_c[$];
   bit         stuck = 0, hold_low = 0, prev_start = 0;
   int         busy_cnt = 0, viol = 0;
   int         total = 0, passed = 0, fails = 0;
   int         v_cyc, first_c;

   initial forever begin
      @(posedge clk);
      pcyc++;
   end

   // UART model: busy for two cycles after each start unless stuck or held low
   initial forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
         if (prev_start || tx_ready !== 1'b1) viol++;
         obs_b.push_back(tx_byte);
         obs_c.push_back(pcyc);
         if (!stuck) begin
            tx_ready = 1'b0;
            busy_cnt = 2;
         end
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0 && !hold_low) tx_ready = 1'b1;
      end else if (!hold_low) begin
         tx_ready = 1'b1;
      end
      if (!rst_n) begin
         tx_ready = 1'b1;
         busy_cnt = 0;
      end
      prev_start = tx_start;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic pulse(input bit c, input bit d, input logic [7:0] cv, input logic [7:0] dv);
      @(negedge clk);
      v_cyc    = pcyc;
      cc_valid = c;
      cc_value = cv;
      dc_valid = d;
      dc_value = dv;
      @(negedge clk);
      cc_valid = 1'b0;
      dc_valid = 1'b0;
   endtask

   task automatic drain(input int n, input string tag);
      logic [7:0] b, e;
      int         w, c;
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (obs_b.size() == 0 && w < 400) begin
            @(negedge clk);
            w++;
         end
         if (obs_b.size() == 0) begin
            chk({tag, "_timeout"}, obs_b.size(), 1);
            exp_q.delete();
            return;
         end
         b = obs_b.pop_front();
         c = obs_c.pop_front();
         if (i == 0) first_c = c;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         chk(tag, b, e);
      end
   endtask

   task automatic wait_idle();
      int run = 0;
      for (int i = 0; i < 3000 && run < 4; i++) begin
         @(negedge clk);
         run = busy ? 0 : run + 1;
      end
      chk("idle_timeout", run, 4);
   endtask

   task automatic push3(input logic [7:0] id, input logic [7:0] v);
      exp_q.push_back(8'hA5);
      exp_q.push_back(id);
      exp_q.push_back(v);
   endtask

   initial begin
      int w;
      repeat (3) @(negedge clk);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      rst_n = 1'b1;

      // single CC frame; valid seen on edge N, tx_start high in the cycle after edge N+2
      push3(8'h01, 8'h3C);
      pulse(1, 0, 8'h3C, 8'h00);
      drain(3, "cc_single");
      chk("cc_latency", first_c - v_cyc, 3);
      wait_idle();
      chk("cc_frame_cnt", frame_cnt, 1);

      // async reset while tx_start is high abandons the frame
      pulse(1, 0, 8'hAA, 8'h00);
      w = 0;
      do begin
         @(posedge clk);
         #1;
         w++;
      end while (tx_start !== 1'b1 && w < 50);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_tx_start", tx_start, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_frame_cnt", frame_cnt, 0);
      chk("midrst_drop_cnt", drop_cnt, 0);
      repeat (2) @(negedge clk);
      obs_b.delete();
      obs_c.delete();
      exp_q.delete();
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("postrst_bytes", obs_b.size(), 0);

      // simultaneous valids, twice: CC first each time
      for (int r = 0; r < 2; r++) begin
         push3(8'h01, 8'h11);
         push3(8'h02, 8'h22);
         pulse(1, 1, 8'h11, 8'h22);
         drain(6, "simul");
         wait_idle();
      end
      chk("simul_frame_cnt", frame_cnt, 4);

      // DC overrun during a CC frame, plus a CC sample that must wait in the shadow
      push3(8'h01, 8'h55);
      push3(8'h02, 8'h03);
      push3(8'h01, 8'h77);
      pulse(1, 0, 8'h55, 8'h00);
      repeat (3) @(negedge clk);
      pulse(0, 1, 8'h00, 8'h01);
      pulse(0, 1, 8'h00, 8'h02);
      pulse(1, 1, 8'h77, 8'h03);
      drain(9, "overrun");
      wait_idle();
      chk("overrun_drop_cnt", drop_cnt, 2);
      chk("overrun_frame_cnt", frame_cnt, 7);

      // stuck UART: same byte re-pulsed every ACC_TIMEOUT+1 cycles
      @(posedge clk);
      stuck = 1;
      pulse(0, 1, 8'h00, 8'h9A);
      w = 0;
      while (obs_b.size() < 3 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("stuck_pulses", obs_b.size() >= 3, 1);
      if (obs_b.size() >= 3) begin
         chk("stuck_b0", obs_b[0], 8'hA5);
         chk("stuck_b1", obs_b[1], 8'hA5);
         chk("stuck_b2", obs_b[2], 8'hA5);
         chk("stuck_gap1", obs_c[1] - obs_c[0], 17);
         chk("stuck_gap2", obs_c[2] - obs_c[1], 17);
      end
      @(posedge clk);
      stuck = 0;
      wait_idle();
      while (obs_b.size() > 2 && obs_b[0] == 8'hA5) begin
         void'(obs_b.pop_front());
         void'(obs_c.pop_front());
      end
      chk("stuck_tail_len", obs_b.size(), 2);
      if (obs_b.size() == 2) begin
         chk("stuck_id", obs_b[0], 8'h02);
         chk("stuck_val", obs_b[1], 8'h9A);
      end
      obs_b.delete();
      obs_c.delete();
      chk("stuck_frame_cnt", frame_cnt, 8);

      // counters: park a CC frame, flood DC overruns, then wrap frame_cnt
      @(posedge clk);
      hold_low = 1;
      push3(8'h01, 8'h10);
      push3(8'h02, 8'h03);
      pulse(1, 0, 8'h10, 8'h00);
      repeat (10) @(negedge clk);
      for (int i = 0; i < 260; i++) pulse(0, 1, 8'h00, 8'(i));
      chk("sat_drop_cnt", drop_cnt, 8'hFF);
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      chk("forced_frame_cnt", frame_cnt, 16'hFFFF);
      release dut.frame_cnt_q;
      @(posedge clk);
      hold_low = 0;
      drain(6, "wrap");
      wait_idle();
      chk("wrap_frame_cnt", frame_cnt, 1);
      chk("sat_drop_hold", drop_cnt, 8'hFF);

      chk("tx_start_protocol", viol, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
